// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
package sipo_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_VALID_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC,
    VALID = ST_VALID_ENC
  } state_e;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Bit-serial input side and word-wide valid/ready output side of the frame controller.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             si;
  logic             si_valid;
  logic             out_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             busy;
  logic             frame_abort;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start, si, si_valid, out_ready, ovr_clr,
    input  po, po_valid, busy, frame_abort, overrun, bit_cnt
  );

  modport slave (
    input  start, si, si_valid, out_ready, ovr_clr,
    output po, po_valid, busy, frame_abort, overrun, bit_cnt
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// Right-shift register: new bits enter at the MSB. A clear applied together with a
// shift yields a register holding only the new bit, which lets a frame start on the same edge.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base = clr ? '0 : q_q;
    q_d  = base;
    if (shift_en) begin
      q_d = {si, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH serial bits after a start strobe, presents the word on a
// valid/ready port, and flags stalled frames (timeout abort) and bits arriving while a word waits.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int TIMEOUT      = 16,
  parameter int AUTO_RESTART = 0
) (
  input  logic              clk,
  input  logic              rst,
  sipo_frame_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;
  logic             sr_clr;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_q;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .si       (bus.si),
    .q        (sr_q)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    po_d      = po_q;
    abort_d   = 1'b0;
    overrun_d = overrun_q & ~bus.ovr_clr;
    sr_clr    = 1'b0;
    sr_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tmo_d     = '0;
          sr_clr    = 1'b1;
        end
      end

      SHIFT: begin
        // A restart strobe beats any bit arriving in the same cycle.
        if (bus.start) begin
          abort_d   = 1'b1;
          bit_cnt_d = '0;
          tmo_d     = '0;
          sr_clr    = 1'b1;
        end else if (bus.si_valid) begin
          tmo_d    = '0;
          sr_shift = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            po_d      = WIDTH'({bus.si, sr_q} >> 1);
            bit_cnt_d = '0;
            state_d   = VALID;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (TIMEOUT != 0) begin
          if (tmo_q == TMO_LAST) begin
            state_d   = IDLE;
            abort_d   = 1'b1;
            bit_cnt_d = '0;
            tmo_d     = '0;
            sr_clr    = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      VALID: begin
        if (bus.out_ready) begin
          if (AUTO_RESTART != 0) begin
            state_d   = SHIFT;
            tmo_d     = '0;
            sr_clr    = 1'b1;
            sr_shift  = bus.si_valid;
            bit_cnt_d = bus.si_valid ? CNT_W'(1) : '0;
          end else begin
            state_d = IDLE;
          end
        end
        // Only an auto-restart handshake can absorb a bit; otherwise it is lost.
        if (bus.si_valid && !(bus.out_ready && (AUTO_RESTART != 0))) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      po_q      <= '0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      po_q      <= po_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.po          = po_q;
  assign bus.po_valid    = (state_q == VALID);
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_abort = abort_q;
  assign bus.overrun     = overrun_q;
  assign bus.bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: one instance without and one with auto-restart,
// both WIDTH=4, TIMEOUT=16.
module tb_sipo_frame_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sipo_frame_ctrl_if #(.WIDTH(4)) if_a ();
  sipo_frame_ctrl_if #(.WIDTH(4)) if_b ();

  sipo_frame_ctrl #(.WIDTH(4), .TIMEOUT(16), .AUTO_RESTART(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sipo_frame_ctrl #(.WIDTH(4), .TIMEOUT(16), .AUTO_RESTART(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs on the selected instance (the other is held quiet).
  task automatic applyStimulus(input bit sel, input logic st, input logic s,
                               input logic v, input logic r, input logic c);
    if (sel == 1'b0) begin
      if_a.start = st; if_a.si = s; if_a.si_valid = v; if_a.out_ready = r; if_a.ovr_clr = c;
      if_b.start = 1'b0; if_b.si = 1'b0; if_b.si_valid = 1'b0; if_b.out_ready = 1'b0; if_b.ovr_clr = 1'b0;
    end else begin
      if_b.start = st; if_b.si = s; if_b.si_valid = v; if_b.out_ready = r; if_b.ovr_clr = c;
      if_a.start = 1'b0; if_a.si = 1'b0; if_a.si_valid = 1'b0; if_a.out_ready = 1'b0; if_a.ovr_clr = 1'b0;
    end
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input bit sel, input string tag, input logic [3:0] e_po,
                            input logic e_pv, input logic e_busy, input logic e_abort,
                            input logic e_ovr, input logic [2:0] e_cnt);
    if (sel == 1'b0) begin
      checkOutput({tag, ".po"},       32'(if_a.po),          32'(e_po));
      checkOutput({tag, ".po_valid"}, 32'(if_a.po_valid),    32'(e_pv));
      checkOutput({tag, ".busy"},     32'(if_a.busy),        32'(e_busy));
      checkOutput({tag, ".abort"},    32'(if_a.frame_abort), 32'(e_abort));
      checkOutput({tag, ".overrun"},  32'(if_a.overrun),     32'(e_ovr));
      checkOutput({tag, ".bit_cnt"},  32'(if_a.bit_cnt),     32'(e_cnt));
    end else begin
      checkOutput({tag, ".po"},       32'(if_b.po),          32'(e_po));
      checkOutput({tag, ".po_valid"}, 32'(if_b.po_valid),    32'(e_pv));
      checkOutput({tag, ".busy"},     32'(if_b.busy),        32'(e_busy));
      checkOutput({tag, ".abort"},    32'(if_b.frame_abort), 32'(e_abort));
      checkOutput({tag, ".overrun"},  32'(if_b.overrun),     32'(e_ovr));
      checkOutput({tag, ".bit_cnt"},  32'(if_b.bit_cnt),     32'(e_cnt));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_a.start = 1'b0; if_a.si = 1'b0; if_a.si_valid = 1'b0; if_a.out_ready = 1'b0; if_a.ovr_clr = 1'b0;
    if_b.start = 1'b0; if_b.si = 1'b0; if_b.si_valid = 1'b0; if_b.out_ready = 1'b0; if_b.ovr_clr = 1'b0;

    // Reset state of both instances
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkState(0, "rst_a", 4'b0000, 0, 0, 0, 0, 3'd0);
    checkState(1, "rst_b", 4'b0000, 0, 0, 0, 0, 3'd0);

    // Basic frame 1,0,1,1 -> 1101 with consumer always ready
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkState(0, "t1_start", 4'b0000, 0, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkState(0, "t1_bit3", 4'b0000, 0, 1, 0, 0, 3'd3);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkState(0, "t1_word", 4'b1101, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkState(0, "t1_done", 4'b1101, 0, 0, 0, 0, 3'd0);

    // Overrun while the word waits; set wins over a simultaneous clear
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkState(0, "t2_word", 4'b1101, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 1);
    checkState(0, "t2_ovr_set", 4'b1101, 1, 1, 0, 1, 3'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState(0, "t2_held", 4'b1101, 1, 1, 0, 1, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkState(0, "t2_hs", 4'b1101, 0, 0, 0, 1, 3'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkState(0, "t2_clr", 4'b1101, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkState(0, "t2_next", 4'b0100, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Timeout after exactly 16 empty cycles
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkState(0, "t3_idle15", 4'b0100, 0, 1, 0, 0, 3'd2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState(0, "t3_abort", 4'b0100, 0, 0, 1, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkState(0, "t3_pulse", 4'b0100, 0, 0, 0, 0, 3'd0);

    // 15 empty cycles then a bit keeps the frame alive
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkState(0, "t3_alive", 4'b0100, 0, 1, 0, 0, 3'd1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkState(0, "t6_cnt3", 4'b0100, 0, 1, 0, 0, 3'd3);

    // Reset mid-frame overrides a concurrent bit
    rst = 1'b1;
    applyStimulus(0, 0, 1, 1, 0, 0);
    rst = 1'b0;
    checkState(0, "t6_rst", 4'b0000, 0, 0, 0, 0, 3'd0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkState(0, "t6_word", 4'b0110, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Restart mid-frame: the bit alongside start is discarded
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkState(0, "t4_restart", 4'b0110, 0, 1, 1, 0, 3'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkState(0, "t4_bit0", 4'b0110, 0, 1, 0, 0, 3'd1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkState(0, "t4_bit2", 4'b0110, 0, 1, 0, 0, 3'd3);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkState(0, "t4_word", 4'b1000, 1, 1, 0, 0, 3'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Auto-restart: bit in the handshake cycle becomes bit 0 of the next frame
    applyStimulus(1, 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    checkState(1, "t5_word1", 4'b0011, 1, 1, 0, 0, 3'd0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    checkState(1, "t5_hs_bit", 4'b0011, 0, 1, 0, 0, 3'd1);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 1, 0);
    checkState(1, "t5_word2", 4'b1100, 1, 1, 0, 0, 3'd0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkState(1, "t5_rearm", 4'b1100, 0, 1, 0, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Frame controller that sequences a serial-in/parallel-out shift register. It accepts qualified serial bits after a start strobe and counts them. When WIDTH bits have arrived it presents the word on a valid/ready output port. It also detects stalled frames (timeout) and bits that arrive while a word is waiting (overrun). It sits between a bit-serial source and any word-wide consumer in the register/datapath library.

Parameters:
WIDTH, 4, word length in bits (>=2)
TIMEOUT, 16, consecutive bit-less cycles in SHIFT before abort; 0 disables timeout
AUTO_RESTART, 0, 1 = return to SHIFT (not IDLE) after a word is consumed
CNT_W (localparam), $clog2(WIDTH+1), bit counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  frame start strobe
si  input  1  serial data bit
si_valid  input  1  si qualifier; one bit accepted per cycle when high
out_ready  input  1  consumer ready for po
ovr_clr  input  1  clears sticky overrun
po  output  WIDTH  parallel word, held stable while po_valid=1
po_valid  output  1  word available
busy  output  1  high in SHIFT or VALID
frame_abort  output  1  one-cycle pulse when a frame is abandoned
overrun  output  1  sticky: bit arrived while word pending
bit_cnt  output  CNT_W  bits accepted in current frame

Behaviour:
- Reset (rst=1 at edge): state=IDLE; po=0, po_valid=0, busy=0, frame_abort=0, overrun=0, bit_cnt=0; shift and timeout counters=0. rst overrides every other input, including mid-frame.
- Shift order: each accepted bit enters the MSB and the shift register shifts right by one. After WIDTH bits, the first received bit sits at po[0] and the last at po[WIDTH-1].
- IDLE: busy=0. si_valid is ignored. start=1 -> SHIFT; shift reg, bit_cnt and timeout counter are cleared.
- SHIFT:
  - Each si_valid increments bit_cnt and clears the timeout counter.
  - If si_valid is accepted while bit_cnt==WIDTH-1: po is loaded with the completed word at that edge, po_valid=1 next cycle (1-cycle latency after the last bit), bit_cnt->0, state->VALID.
  - start=1 while in SHIFT: the frame restarts (counters and shift reg cleared) and frame_abort pulses. Any si_valid in the same cycle is discarded; start wins.
  - Timeout (TIMEOUT>0): a counter increments on each SHIFT cycle without si_valid. If it equals TIMEOUT-1 and si_valid=0 -> IDLE, frame_abort pulse, partial data discarded, po unchanged. An abort therefore occurs after exactly TIMEOUT consecutive empty cycles.
- VALID: po_valid=1 and po is held constant.
  - out_ready=1 completes the handshake at that edge; po_valid falls next cycle.
  - After the handshake: AUTO_RESTART=0 -> IDLE; AUTO_RESTART=1 -> SHIFT with counters cleared.
  - AUTO_RESTART=1 with out_ready=1 and si_valid=1 in the same cycle: the bit is accepted as bit 0 of the next frame (bit_cnt=1).
  - si_valid=1 without a completing handshake (out_ready=0, or AUTO_RESTART=0): the bit is dropped and overrun is set.
  - start is ignored in VALID.
- overrun: set as above; cleared by ovr_clr or rst. Set has priority if set and ovr_clr occur in the same cycle.
- frame_abort is a registered one-cycle pulse, 0 otherwise.
- po retains the last delivered word until the next word completes.

Decomposition:
- Shared package sipo_pkg: state enum (IDLE, SHIFT, VALID), 2-bit encoding constants.
- Sub-module sipo_shift_reg (WIDTH; clk, rst, clr, shift_en, si, q). It is a parameterised right-shift register with synchronous clear.
- The controller owns the FSM, counters, output register and flags.

Test Plan:
- WIDTH=4: start, then bits 1,0,1,1 on consecutive cycles, out_ready=1 -> po=4'b1101, po_valid high 1 cycle after the 4th bit, then IDLE, busy=0.
- out_ready=0 for 5 cycles after word 4'b1101, si_valid pulsed once -> po held at 1101, overrun=1 until ovr_clr, dropped bit not in the next word.
- start, 2 bits, then 16 idle cycles (TIMEOUT=16) -> frame_abort at cycle 16 exactly, state IDLE, po unchanged; 15 idle cycles then a bit -> no abort.
- start, bits 1,1, start again with si_valid=1, then bits 0,0,0,1 -> frame_abort pulse, po=4'b1000.
- AUTO_RESTART=1: two back-to-back frames 1100/0011 with out_ready=1, bit sent in handshake cycle -> words 4'b0011 then 4'b1100, no overrun.
- rst asserted with bit_cnt=3 -> all outputs 0 next cycle; a fresh frame 0,1,1,0 -> po=4'b0110.
